fetch_queue: RTL and testbench

- Instruction buffer between the fetch stage (PC register plus next-PC select) and decode.
- Captures each {pc, instruction} pair from instruction memory and presents pairs to decode in order.
- Decode consumes pairs through a valid/ready handshake. Decode stalls never back-pressure instruction memory until the queue is full.
- A flush input discards all buffered entries when a taken branch or jump redirects the PC.

---
 rtl/fetch_queue.sv | 87 ++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: holds {pc, instr} pairs in a
// circular buffer, hands them to decode in order, and empties on a redirect.
module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDRESS_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0]      in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDRESS_WIDTH-1:0]   out_pc,
    output logic [ADDRESS_WIDTH-1:0]   out_pc_plus4,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]         FULL = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0]    NOP  = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     push;
    logic                     pop;

    // Readiness depends only on occupancy, so a full queue never accepts a
    // push in the same cycle as a pop.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        out_pc    = '0;
        out_instr = NOP;
        if (out_valid) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
    end

    assign out_pc_plus4 = out_pc + FOUR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Redirect: everything buffered and the pair on the input is wrong-path.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, streaming with wrap,
// full-with-pop, flush and PC+4 wrap, all against hand-computed values.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_pc"}, 64'(out_pc), 64'(pc));
        check({tag, "_pc4"}, 64'(out_pc_plus4), 64'(pc + 32'd4));
        check({tag, "_instr"}, 64'(out_instr), 64'(instr));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_instr"}, 64'(out_instr), 64'h13);
        check({tag, "_pc"}, 64'(out_pc), 64'(0));
        check({tag, "_pc4"}, 64'(out_pc_plus4), 64'(4));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #1;
        check_empty("por");
        #20;
        rst = 1'b0;
        #2;

        // Fill with decode stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 64'(in_ready), 64'(1));
            push_one(32'(4 * i), 32'hA0 + 32'(i));
        end
        check("fill_count", 64'(count), 64'(4));
        check("fill_full", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("drain", 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        check_empty("drained");
        out_ready = 1'b0;

        // No fall-through: a pushed pair shows up one cycle later.
        in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'hAA;
        check("lat_before", 64'(out_valid), 64'(0));
        tick();
        in_valid = 1'b0;
        check_head("lat_after", 32'h40, 32'hAA);
        out_ready = 1'b1;
        tick();
        check("lat_pop_count", 64'(count), 64'(0));

        // Streaming across pointer wrap: one push and one pop per cycle.
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1000 + 32'(4 * k);
            in_instr = 32'hB0 + 32'(k);
            if (k > 0) begin
                check("stream_count", 64'(count), 64'(1));
                check_head("stream", 32'h1000 + 32'(4 * (k - 1)), 32'hB0 + 32'(k - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        check_head("stream_last", 32'h1024, 32'hB9);
        tick();
        check("stream_end_count", 64'(count), 64'(0));

        // Full with a simultaneous pop: pop first, push one cycle later.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(4 * i), 32'hD0 + 32'(i));
        in_valid = 1'b1; in_pc = 32'h310; in_instr = 32'hD4; out_ready = 1'b1;
        check("full_pop_ready", 64'(in_ready), 64'(0));
        tick();
        check("full_pop_count", 64'(count), 64'(3));
        check_head("full_pop_head", 32'h304, 32'hD1);
        check("full_pop_ready2", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        check("pushpop_count", 64'(count), 64'(3));
        check_head("fp_a", 32'h308, 32'hD2);
        tick();
        check_head("fp_b", 32'h30C, 32'hD3);
        tick();
        check_head("fp_c", 32'h310, 32'hD4);
        tick();
        check("fp_empty", 64'(out_valid), 64'(0));

        // Flush with a concurrent push and pop drops everything.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(4 * i), 32'hE0 + 32'(i));
        check("pre_flush_count", 64'(count), 64'(3));
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hEE; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_empty("flush");
        push_one(32'h200, 32'hC0);
        check("post_flush_count", 64'(count), 64'(1));
        check_head("post_flush", 32'h200, 32'hC0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4 * i), 32'hF0 + 32'(i));
        check("pre_rst_count", 64'(count), 64'(3));
        #2;
        rst = 1'b1;
        #1;
        check_empty("async_rst");
        tick();
        #2;
        rst = 1'b0;
        in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'h77;
        check("post_rst_before", 64'(out_valid), 64'(0));
        tick();
        in_valid = 1'b0;
        check("post_rst_count", 64'(count), 64'(1));
        check_head("post_rst", 32'h600, 32'h77);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // PC+4 wraps modulo 2^32.
        push_one(32'hFFFF_FFFC, 32'h55);
        check("wrap_pc", 64'(out_pc), 64'hFFFF_FFFC);
        check("wrap_pc4", 64'(out_pc_plus4), 64'(0));
        out_ready = 1'b1;
        tick();
        check("wrap_empty", 64'(count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
